// File: rtl/scu_pkg.sv
// Shared SCU pipeline definitions: opcodes, ALU encodings and the control bundle.
package scu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SVPC = 4'b1111;
    localparam logic [OPCODE_W-1:0] OP_LD   = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_INC  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_J    = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_BRZ  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_JM   = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_BRN  = 4'b1011;

    localparam logic [ALUOP_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_NEG  = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b011;

    typedef struct packed {
        logic               brz;
        logic               brn;
        logic               j;
        logic               regw;
        logic               wai;
        logic               memw;
        logic               memr;
        logic               alusrc;
        logic               svpc;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    // Control bundle for an opcode; unknown opcodes behave as NOP.
    function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_SVPC: begin c.regw = 1'b1; c.alusrc = 1'b1; c.svpc = 1'b1; c.aluop = ALU_ADD; end
            OP_LD:   begin c.regw = 1'b1; c.memr = 1'b1; c.wai = 1'b1; end
            OP_ST:   begin c.memw = 1'b1; end
            OP_ADD:  begin c.regw = 1'b1; c.aluop = ALU_ADD; end
            OP_INC:  begin c.regw = 1'b1; c.alusrc = 1'b1; c.aluop = ALU_ADD; end
            OP_NEG:  begin c.regw = 1'b1; c.aluop = ALU_NEG; end
            OP_SUB:  begin c.regw = 1'b1; c.aluop = ALU_SUB; end
            OP_J:    begin c.j = 1'b1; end
            OP_BRZ:  begin c.brz = 1'b1; end
            OP_JM:   begin c.j = 1'b1; c.memr = 1'b1; end
            OP_BRN:  begin c.brn = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // True when the opcode reads the rs register.
    function automatic logic uses_rs(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
            OP_J, OP_BRZ, OP_JM, OP_BRN: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    // True when the opcode reads the rt register.
    function automatic logic uses_rt(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ST, OP_BRZ, OP_BRN: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file, two combinational read ports, one write port, optional write-through.
module regfile_bypass #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 6,
    parameter int unsigned BYPASS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    output logic [XLEN-1:0]    rdata_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [XLEN-1:0]    rdata_b
);

    localparam int unsigned NREG   = 2 ** RADDR_W;
    localparam logic        BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic            hit_a;
    logic            hit_b;

    // Next register contents: single write port.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports; a same-cycle write wins when write-through is enabled.
    always_comb begin
        hit_a   = BYP_EN && we && (waddr == raddr_a);
        hit_b   = BYP_EN && we && (waddr == raddr_b);
        rdata_a = hit_a ? wdata : mem_q[raddr_a];
        rdata_b = hit_b ? wdata : mem_q[raddr_b];
    end

endmodule

// File: rtl/id_stage_pipe.sv
// SCU decode stage: field decode, control, register read, load-use stall, ID/EX buffer.
module id_stage_pipe
    import scu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 6,
    parameter int unsigned IMM_W   = 22,
    parameter int unsigned BYPASS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_instr,
    output logic               id_ready,
    input  logic               ex_ready,
    input  logic               flush,
    input  logic               ex_memr,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs_data,
    output logic [XLEN-1:0]    out_rt_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_brz,
    output logic               out_brn,
    output logic               out_j,
    output logic               out_regw,
    output logic               out_wai,
    output logic               out_memw,
    output logic               out_memr,
    output logic               out_alusrc,
    output logic               out_svpc,
    output logic [2:0]         out_aluop
);

    localparam int unsigned FIELD_W = 6;

    logic [OPCODE_W-1:0] opcode;
    logic [FIELD_W-1:0]  rd_f;
    logic [FIELD_W-1:0]  rs_f;
    logic [FIELD_W-1:0]  rt_f;
    logic [RADDR_W-1:0]  rd_a;
    logic [RADDR_W-1:0]  rs_a;
    logic [RADDR_W-1:0]  rt_a;
    logic [IMM_W-1:0]    imm_raw;
    logic [XLEN-1:0]     imm_ext;
    ctrl_t               ctrl_dec;
    logic                rs_use;
    logic                rt_use;
    logic                hazard;
    logic                ready_c;
    logic [XLEN-1:0]     rs_rdata;
    logic [XLEN-1:0]     rt_rdata;

    logic                valid_q,   valid_d;
    ctrl_t               ctrl_q,    ctrl_d;
    logic [XLEN-1:0]     pc_q,      pc_d;
    logic [XLEN-1:0]     rs_data_q, rs_data_d;
    logic [XLEN-1:0]     rt_data_q, rt_data_d;
    logic [XLEN-1:0]     imm_q,     imm_d;
    logic [RADDR_W-1:0]  rd_q,      rd_d;

    regfile_bypass #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .BYPASS  (BYPASS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs_a),
        .rdata_a (rs_rdata),
        .raddr_b (rt_a),
        .rdata_b (rt_rdata)
    );

    // Field extraction, control decode and load-use detection.
    always_comb begin
        opcode   = in_instr[31:28];
        rd_f     = in_instr[27:22];
        rs_f     = in_instr[21:16];
        rt_f     = in_instr[15:10];
        rd_a     = rd_f[RADDR_W-1:0];
        rs_a     = rs_f[RADDR_W-1:0];
        rt_a     = rt_f[RADDR_W-1:0];
        imm_raw  = in_instr[IMM_W-1:0];
        imm_ext  = XLEN'($signed(imm_raw));
        ctrl_dec = decode_ctrl(opcode);
        rs_use   = uses_rs(opcode);
        rt_use   = uses_rt(opcode);
        hazard   = ex_memr && valid_q &&
                   ((rs_use && (ex_rd == rs_a)) || (rt_use && (ex_rd == rt_a)));
    end

    // ID/EX next state by priority: flush, downstream stall, bubble, capture.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        ready_c   = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            ready_c = 1'b1;
        end else if (!ex_ready) begin
            ready_c = 1'b0;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d   = in_valid;
            ctrl_d    = in_valid ? ctrl_dec : '0;
            pc_d      = in_pc;
            rs_data_d = rs_rdata;
            rt_data_d = rt_rdata;
            imm_d     = imm_ext;
            rd_d      = rd_a;
            ready_c   = 1'b1;
        end
    end

    // ID/EX buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
        end
    end

    // Output mapping.
    always_comb begin
        id_ready    = ready_c;
        out_valid   = valid_q;
        out_pc      = pc_q;
        out_rs_data = rs_data_q;
        out_rt_data = rt_data_q;
        out_imm     = imm_q;
        out_rd      = rd_q;
        out_brz     = ctrl_q.brz;
        out_brn     = ctrl_q.brn;
        out_j       = ctrl_q.j;
        out_regw    = ctrl_q.regw;
        out_wai     = ctrl_q.wai;
        out_memw    = ctrl_q.memw;
        out_memr    = ctrl_q.memr;
        out_alusrc  = ctrl_q.alusrc;
        out_svpc    = ctrl_q.svpc;
        out_aluop   = ctrl_q.aluop;
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode table plus stall/flush/bypass/reset sequences.
module tb_id_stage_pipe;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            ex_ready, flush, ex_memr, wb_we;
    logic [RW-1:0]   ex_rd, wb_rd;
    logic [31:0]     wb_data;

    logic            id_ready, out_valid;
    logic [31:0]     out_pc, out_rs_data, out_rt_data, out_imm;
    logic [RW-1:0]   out_rd;
    logic            out_brz, out_brn, out_j, out_regw, out_wai, out_memw, out_memr, out_alusrc, out_svpc;
    logic [2:0]      out_aluop;

    logic            b0_id_ready, b0_out_valid;
    logic [31:0]     b0_out_pc, b0_out_rs_data, b0_out_rt_data, b0_out_imm;
    logic [RW-1:0]   b0_out_rd;
    logic            b0_brz, b0_brn, b0_j, b0_regw, b0_wai, b0_memw, b0_memr, b0_alusrc, b0_svpc;
    logic [2:0]      b0_aluop;

    logic [11:0]     act_ctrl;
    assign act_ctrl = {out_brz, out_brn, out_j, out_regw, out_wai, out_memw,
                       out_memr, out_alusrc, out_svpc, out_aluop};

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .RADDR_W(RW), .IMM_W(22), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_memr(ex_memr), .ex_rd(ex_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_pc(out_pc),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm), .out_rd(out_rd),
        .out_brz(out_brz), .out_brn(out_brn), .out_j(out_j), .out_regw(out_regw), .out_wai(out_wai),
        .out_memw(out_memw), .out_memr(out_memr), .out_alusrc(out_alusrc), .out_svpc(out_svpc),
        .out_aluop(out_aluop)
    );

    id_stage_pipe #(.XLEN(XLEN), .RADDR_W(RW), .IMM_W(22), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .id_ready(b0_id_ready), .ex_ready(ex_ready), .flush(flush), .ex_memr(ex_memr), .ex_rd(ex_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(b0_out_valid), .out_pc(b0_out_pc),
        .out_rs_data(b0_out_rs_data), .out_rt_data(b0_out_rt_data), .out_imm(b0_out_imm), .out_rd(b0_out_rd),
        .out_brz(b0_brz), .out_brn(b0_brn), .out_j(b0_j), .out_regw(b0_regw), .out_wai(b0_wai),
        .out_memw(b0_memw), .out_memr(b0_memr), .out_alusrc(b0_alusrc), .out_svpc(b0_svpc),
        .out_aluop(b0_aluop)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                       input logic [5:0] rs, input logic [5:0] rt,
                                       input logic [9:0] lo);
        return {op, rd, rs, rt, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exp_valid;
        logic [11:0] exp_ctrl;
        logic [31:0] exp_imm;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [5:0]  exp_rd;
        logic        chk_data;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // rd=5 rs=r1(0x11) rt=r2(0x22) low=0x155 -> imm = 0x00010955
        vecs[0]  = '{1'b1, mk(4'b0000,6'd5,6'd1,6'd2,10'h155), 32'h100, 1'b1, 12'b000000000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[1]  = '{1'b1, mk(4'b1111,6'd5,6'd1,6'd2,10'h155), 32'h104, 1'b1, 12'b000100011_001, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[2]  = '{1'b1, mk(4'b1110,6'd5,6'd1,6'd2,10'h155), 32'h108, 1'b1, 12'b000110100_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[3]  = '{1'b1, mk(4'b0011,6'd5,6'd1,6'd2,10'h155), 32'h10C, 1'b1, 12'b000001000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[4]  = '{1'b1, mk(4'b0100,6'd5,6'd1,6'd2,10'h155), 32'h110, 1'b1, 12'b000100000_001, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[5]  = '{1'b1, mk(4'b0101,6'd5,6'd1,6'd2,10'h155), 32'h114, 1'b1, 12'b000100010_001, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[6]  = '{1'b1, mk(4'b0110,6'd5,6'd1,6'd2,10'h155), 32'h118, 1'b1, 12'b000100000_010, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[7]  = '{1'b1, mk(4'b0111,6'd5,6'd1,6'd2,10'h155), 32'h11C, 1'b1, 12'b000100000_011, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[8]  = '{1'b1, mk(4'b1000,6'd5,6'd1,6'd2,10'h155), 32'h120, 1'b1, 12'b001000000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[9]  = '{1'b1, mk(4'b1001,6'd5,6'd1,6'd2,10'h155), 32'h124, 1'b1, 12'b100000000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[10] = '{1'b1, mk(4'b1010,6'd5,6'd1,6'd2,10'h155), 32'h128, 1'b1, 12'b001000100_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        vecs[11] = '{1'b1, mk(4'b1011,6'd5,6'd1,6'd2,10'h155), 32'h12C, 1'b1, 12'b010000000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        // undefined opcode behaves as NOP
        vecs[12] = '{1'b1, mk(4'b1101,6'd5,6'd1,6'd2,10'h155), 32'h130, 1'b1, 12'b000000000_000, 32'h00010955, 32'h11, 32'h22, 6'd5, 1'b1};
        // no valid instruction: bubble with control cleared
        vecs[13] = '{1'b0, mk(4'b0100,6'd5,6'd1,6'd2,10'h155), 32'h134, 1'b0, 12'b000000000_000, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0};
        // imm bit 21 set -> negative immediate; rs=r32, rt=r0 both unwritten
        vecs[14] = '{1'b1, mk(4'b1111,6'd4,6'd32,6'd0,10'h001), 32'h138, 1'b1, 12'b000100011_001, 32'hFFE00001, 32'h0, 32'h0, 6'd4, 1'b1};
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        ex_ready = 1'b1; flush = 1'b0; ex_memr = 1'b0; ex_rd = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ctrl", 64'(act_ctrl), 64'h0);
        chk("rst_pc", 64'(out_pc), 64'h0);
        chk("rst_rs", 64'(out_rs_data), 64'h0);
        chk("rst_imm", 64'(out_imm), 64'h0);
        chk("rst_rd", 64'(out_rd), 64'h0);
        chk("rst_ready", 64'(id_ready), 64'h1);
        #11;
        rst_n = 1'b1;
        tick();

        // preload r1, r2, r5
        wb_we = 1'b1; wb_rd = 6'd1; wb_data = 32'h11; tick();
        wb_rd = 6'd2; wb_data = 32'h22; tick();
        wb_rd = 6'd5; wb_data = 32'h55; tick();
        wb_we = 1'b0;

        // decode table
        for (int i = 0; i < 15; i++) begin
            in_valid = vecs[i].v; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(id_ready), 64'h1);
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_ctrl", i), 64'(act_ctrl), 64'(vecs[i].exp_ctrl));
            if (vecs[i].chk_data) begin
                chk($sformatf("tbl%0d_pc", i), 64'(out_pc), 64'(vecs[i].pc));
                chk($sformatf("tbl%0d_imm", i), 64'(out_imm), 64'(vecs[i].exp_imm));
                chk($sformatf("tbl%0d_rs", i), 64'(out_rs_data), 64'(vecs[i].exp_rs));
                chk($sformatf("tbl%0d_rt", i), 64'(out_rt_data), 64'(vecs[i].exp_rt));
                chk($sformatf("tbl%0d_rd", i), 64'(out_rd), 64'(vecs[i].exp_rd));
            end
        end

        // write-through: WB r3 and ADD rs=r3 in the same cycle
        in_valid = 1'b1; in_pc = 32'h200; in_instr = mk(4'b0100, 6'd6, 6'd3, 6'd0, 10'h0);
        wb_we = 1'b1; wb_rd = 6'd3; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        chk("byp1_rs", 64'(out_rs_data), 64'h1234);
        chk("byp0_rs_old", 64'(b0_out_rs_data), 64'h0);
        tick();
        chk("byp1_rs_stored", 64'(out_rs_data), 64'h1234);
        chk("byp0_rs_stored", 64'(b0_out_rs_data), 64'h1234);

        // load-use: LD in EX writes r7, ADD reads rt=r7
        in_pc = 32'h300; in_instr = mk(4'b0100, 6'd8, 6'd1, 6'd7, 10'h0);
        ex_memr = 1'b1; ex_rd = 6'd7;
        #1;
        chk("haz_ready", 64'(id_ready), 64'h0);
        tick();
        chk("haz_bubble_valid", 64'(out_valid), 64'h0);
        chk("haz_bubble_ctrl", 64'(act_ctrl), 64'h0);
        ex_memr = 1'b0;
        #1;
        chk("haz_release_ready", 64'(id_ready), 64'h1);
        tick();
        chk("haz_issue_valid", 64'(out_valid), 64'h1);
        chk("haz_issue_aluop", 64'(out_aluop), 64'h1);
        chk("haz_issue_pc", 64'(out_pc), 64'h300);
        chk("haz_issue_rs", 64'(out_rs_data), 64'h11);

        // downstream stall for three cycles holds ID/EX
        in_pc = 32'h400; in_instr = mk(4'b0111, 6'd9, 6'd2, 6'd1, 10'h0);
        tick();
        ex_ready = 1'b0; in_pc = 32'h404; in_instr = mk(4'b1000, 6'd0, 6'd5, 6'd0, 10'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), 64'(id_ready), 64'h0);
            tick();
            chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'h1);
            chk($sformatf("stall%0d_ctrl", c), 64'(act_ctrl), 64'(12'b000100000_011));
            chk($sformatf("stall%0d_pc", c), 64'(out_pc), 64'h400);
            chk($sformatf("stall%0d_rs", c), 64'(out_rs_data), 64'h22);
            chk($sformatf("stall%0d_rt", c), 64'(out_rt_data), 64'h11);
        end

        // flush beats both stall and hazard
        in_instr = mk(4'b0100, 6'd1, 6'd2, 6'd0, 10'h0);
        ex_memr = 1'b1; ex_rd = 6'd2; flush = 1'b1;
        #1;
        chk("flush_ready", 64'(id_ready), 64'h1);
        tick();
        chk("flush_valid", 64'(out_valid), 64'h0);
        chk("flush_ctrl", 64'(act_ctrl), 64'h0);
        flush = 1'b0; ex_memr = 1'b0; ex_ready = 1'b1;

        // reset mid-stream clears ID/EX at once and the register file
        in_pc = 32'h500; in_instr = mk(4'b0100, 6'd2, 6'd5, 6'd0, 10'h0);
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'h1);
        chk("pre_rst_rs", 64'(out_rs_data), 64'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_ctrl", 64'(act_ctrl), 64'h0);
        chk("mid_rst_pc", 64'(out_pc), 64'h0);
        chk("mid_rst_rs", 64'(out_rs_data), 64'h0);
        chk("mid_rst_imm", 64'(out_imm), 64'h0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'h1);
        chk("post_rst_r5", 64'(out_rs_data), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage for the SCU pipeline. It combines instruction field decode, control generation, a multi-register register file with write-through bypass, load-use hazard detection and a registered ID/EX buffer. Valid/ready handshakes connect it to IF upstream and EX downstream, and a flush input squashes it after a taken branch or jump. It sits between the IF/ID buffer and the EX stage and replaces the fixed-width, stall-less decode stage.

Parameters:
XLEN, 32, datapath width of register data, PC and immediate outputs
RADDR_W, 6, register address width; register count is 2**RADDR_W
IMM_W, 22, immediate field width taken from instr[IMM_W-1:0], sign-extended to XLEN
BYPASS, 1, 1 = WB write visible to same-cycle read; 0 = read returns old value

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds a valid instruction
in_pc  in  XLEN  PC of the instruction
in_instr  in  32  instruction word
id_ready  out  1  ID consumes the current instruction this cycle
ex_ready  in  1  EX accepts the ID/EX contents this cycle
flush  in  1  squash ID and ID/EX (taken branch or jump)
ex_memr  in  1  instruction now in EX is a load
ex_rd  in  RADDR_W  destination register of the instruction in EX
wb_we  in  1  register file write enable
wb_rd  in  RADDR_W  write address
wb_data  in  XLEN  write data
out_valid  out  1  ID/EX holds a valid instruction
out_pc, out_rs_data, out_rt_data, out_imm  out  XLEN  buffered PC, operands and immediate
out_rd  out  RADDR_W  buffered destination register
out_brz, out_brn, out_j, out_regw, out_wai, out_memw, out_memr, out_alusrc, out_svpc  out  1 each  buffered control bits
out_aluop  out  3  buffered ALU operation

Behaviour:
- Fields: opcode = instr[31:28], rd = instr[27:22], rs = instr[21:16], rt = instr[15:10]. Field positions are fixed; only the low RADDR_W bits of each register field are used when RADDR_W < 6.
- Opcodes: NOP 0000, SVPC 1111, LD 1110, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011. Any other opcode decodes as NOP.
- Control: regw for SVPC/LD/ADD/INC/NEG/SUB; memr for LD/JM; memw for ST; alusrc for INC/SVPC; j for J/JM; wai for LD.
- aluop: 000 pass, 001 add, 010 neg, 011 sub.
- Source use: rs is used by all except NOP/SVPC. rt is used by ADD/SUB/ST/BRZ/BRN.
- Register file: 2**RADDR_W x XLEN, two combinational read ports, one write port. Writes on the rising edge when wb_we=1. Reset clears all registers to 0.
- Bypass (BYPASS=1): if wb_we=1 and wb_rd equals a read address, that read returns wb_data.
- hazard = ex_memr & out_valid & (ex_rd matches a used source register).
- Priority, evaluated each cycle:
  1. flush=1: out_valid<=0, id_ready=1, instruction discarded.
  2. Else ex_ready=0: ID/EX holds, id_ready=0.
  3. Else hazard: bubble inserted (out_valid<=0, control bits<=0), id_ready=0.
  4. Else: ID/EX<=decode(in_*), out_valid<=in_valid, id_ready=1.
- Latency: one cycle from accepted instruction to out_*.
- A bubble, and any cycle with out_valid=0, forces all control outputs to 0.
- Reset (asynchronous, any time, including mid-stall): all out_* = 0, out_valid = 0, registers cleared. id_ready is combinational and equals 1 while no hazard applies.
- Simultaneous WB write and ID/EX capture of the same register: the captured operand is the new data when BYPASS=1.

Decomposition:
- Package scu_pkg: opcode localparams, aluop encodings, and a packed control-bundle struct shared with the EX and MEM stages.
- One natural sub-module: regfile_bypass (parametrised XLEN/RADDR_W/BYPASS). Decode logic and hazard logic stay in id_stage_pipe.

Test Plan:
- Reset mid-stream: assert rst_n=0 with out_valid=1 -> out_valid=0 and all outputs 0 immediately; a later read of r5 returns 0.
- WB writes r3=0x1234 with ADD rs=r3 in ID the same cycle -> next cycle out_rs_data=0x1234 (BYPASS=1), old value with BYPASS=0.
- LD in EX with ex_rd=r7, ADD rt=r7 in ID -> id_ready=0, one bubble (out_valid=0); next cycle ADD issues with out_aluop=001.
- ex_ready=0 for 3 cycles -> out_* held stable, id_ready=0 throughout.
- flush=1 together with ex_ready=0 and hazard -> out_valid=0 next cycle, id_ready=1.
- Opcode 1101 -> decoded as NOP: all control bits 0, out_valid follows in_valid.
